// File: rtl/filter_unwind.sv
// Sink-side unwinder for a chain of rotate-left-by-1 filter stages.
// Rotates each 17-bit {data, parity} word right by STAGES % 17, then queues it in a 2-entry elastic buffer.
module filter_unwind #(
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      io_x_data,
  input  logic             io_x_parity,
  input  logic             io_x_valid,
  output logic             io_x_ready,
  output logic [15:0]      io_y_data,
  output logic             io_y_parity,
  output logic             io_y_valid,
  input  logic             io_y_ready,
  output logic [CNT_W-1:0] io_count
);

  localparam int ROT = STAGES % 17;

  // Rotate right by ROT: shifting the doubled word feeds the low bits back in at the top.
  function automatic logic [16:0] unwind(input logic [16:0] w);
    logic [33:0] dbl;
    dbl = {w, w};
    dbl = dbl >> ROT;
    return dbl[16:0];
  endfunction

  logic [1:0]       occ_r;
  logic [16:0]      head_r;
  logic [16:0]      tail_r;
  logic             ready_r;
  logic             valid_r;
  logic [CNT_W-1:0] cnt_r;

  logic             acc_s;
  logic             del_s;
  logic [16:0]      w_s;
  logic [1:0]       occ_nxt_s;
  logic [16:0]      head_nxt_s;
  logic [16:0]      tail_nxt_s;

  assign w_s   = unwind({io_x_data, io_x_parity});
  assign acc_s = io_x_valid & ready_r;
  assign del_s = valid_r & io_y_ready;

  // Next buffer state: head is always the oldest word; it keeps its value when the buffer drains.
  always_comb begin
    occ_nxt_s  = occ_r;
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    case ({acc_s, del_s})
      2'b10: begin
        occ_nxt_s = occ_r + 2'd1;
        if (occ_r == 2'd0) begin
          head_nxt_s = w_s;
        end else begin
          tail_nxt_s = w_s;
        end
      end
      2'b01: begin
        occ_nxt_s = occ_r - 2'd1;
        if (occ_r == 2'd2) begin
          head_nxt_s = tail_r;
        end else begin
          head_nxt_s = head_r;
        end
      end
      2'b11: begin
        // Only reachable at occ=1 (full blocks accept, empty blocks deliver): new word becomes head.
        if (occ_r == 2'd1) begin
          head_nxt_s = w_s;
        end else begin
          head_nxt_s = head_r;
        end
      end
      default: begin
        occ_nxt_s = occ_r;
      end
    endcase
  end

  // Buffer, handshake flags and delivered-word counter; flags derive from next occupancy only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_r   <= 2'd0;
      head_r  <= 17'd0;
      tail_r  <= 17'd0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      occ_r   <= occ_nxt_s;
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      ready_r <= (occ_nxt_s != 2'd2);
      valid_r <= (occ_nxt_s != 2'd0);
      if (del_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign io_x_ready  = ready_r;
  assign io_y_valid  = valid_r;
  assign io_y_data   = head_r[16:1];
  assign io_y_parity = head_r[0];
  assign io_count    = cnt_r;

endmodule

// File: tb/tb_filter_unwind.sv
// Directed bench for filter_unwind: main instance STAGES=2/CNT_W=4, side instance STAGES=1/CNT_W=16.
module tb_filter_unwind;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] io_x_data;
  logic        io_x_parity;
  logic        io_x_valid;
  logic        io_y_ready;

  logic        a_x_ready, a_y_parity, a_y_valid;
  logic [15:0] a_y_data;
  logic [3:0]  a_count;
  logic        b_x_ready, b_y_parity, b_y_valid;
  logic [15:0] b_y_data;
  logic [15:0] b_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          delivered;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  filter_unwind #(.STAGES(2), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset),
    .io_x_data(io_x_data), .io_x_parity(io_x_parity), .io_x_valid(io_x_valid), .io_x_ready(a_x_ready),
    .io_y_data(a_y_data), .io_y_parity(a_y_parity), .io_y_valid(a_y_valid), .io_y_ready(io_y_ready),
    .io_count(a_count)
  );

  filter_unwind #(.STAGES(1), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset),
    .io_x_data(io_x_data), .io_x_parity(io_x_parity), .io_x_valid(io_x_valid), .io_x_ready(b_x_ready),
    .io_y_data(b_y_data), .io_y_parity(b_y_parity), .io_y_valid(b_y_valid), .io_y_ready(io_y_ready),
    .io_count(b_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] rot2(input logic [16:0] w);
    return {w[1:0], w[16:2]};
  endfunction

  // One clock: score the handshakes seen before the edge, then advance to #1 after it.
  task automatic step();
    bit acc, del;
    acc = io_x_valid && a_x_ready && reset;
    del = a_y_valid && io_y_ready && reset;
    if (del) begin
      delivered++;
      if (exp_q.size() == 0) begin
        check("spurious_word", 32'd1, 32'd0);
      end else begin
        check("order_data", {15'd0, a_y_data, a_y_parity}, {15'd0, exp_q.pop_front()});
      end
    end
    if (acc) exp_q.push_back(rot2({io_x_data, io_x_parity}));
    if (!reset) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic p);
    bit took;
    bit done;
    done = 1'b0;
    io_x_data   = d;
    io_x_parity = p;
    io_x_valid  = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      took = a_x_ready;
      step();
      done = took;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    io_x_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && a_y_valid; i++) step();
    check("drain_empty", {31'd0, a_y_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; io_x_valid = 1'b1; io_x_data = 16'hFFFF; io_x_parity = 1'b1; io_y_ready = 1'b0;
    delivered = 0;
    @(posedge clk); #1;
    step(); step(); step();
    check("rst_y_valid", {31'd0, a_y_valid}, 32'd0);
    check("rst_x_ready", {31'd0, a_x_ready}, 32'd0);
    check("rst_count",   {28'd0, a_count}, 32'd0);
    check("rst_y_data",  {16'd0, a_y_data}, 32'd0);
    io_x_valid = 1'b0;
    reset = 1'b1;
    check("ready_before_edge", {31'd0, a_x_ready}, 32'd0);
    step();
    check("ready_after_release", {31'd0, a_x_ready}, 32'd1);

    // STAGES=1 vector on u_b, STAGES=2 on u_a
    send(16'h8001, 1'b0);
    check("s1_valid",  {31'd0, b_y_valid}, 32'd1);
    check("s1_data",   {16'd0, b_y_data}, 32'h4000);
    check("s1_parity", {31'd0, b_y_parity}, 32'd1);
    io_y_ready = 1'b1;
    step();
    check("s1_count",     {16'd0, b_count}, 32'd1);
    check("s1_empty",     {31'd0, b_y_valid}, 32'd0);
    check("s1_hold_data", {16'd0, b_y_data}, 32'h4000);

    io_y_ready = 1'b0;
    send(16'hA5A5, 1'b1);
    check("s2_data",   {16'd0, a_y_data}, 32'hE969);
    check("s2_parity", {31'd0, a_y_parity}, 32'd0);
    io_y_ready = 1'b1;
    step();
    check("s2_count", {28'd0, a_count}, 32'd2);

    // Backpressure: two words fill the buffer, third is held off
    io_y_ready = 1'b0;
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b1);
    check("bp_full_ready", {31'd0, a_x_ready}, 32'd0);
    io_x_data = 16'h3333; io_x_parity = 1'b1; io_x_valid = 1'b1;
    step(); step();
    check("bp_still_full", {31'd0, a_x_ready}, 32'd0);
    check("bp_head_held",  {16'd0, a_y_data}, 32'h8444);
    check("bp_head_par",   {31'd0, a_y_parity}, 32'd0);
    io_y_ready = 1'b1;
    send(16'h3333, 1'b1);
    drain();
    check("bp_all_out", exp_q.size(), 32'd0);
    check("bp_count",   {28'd0, a_count}, 32'd5);

    // Streaming at one word per cycle
    delivered = 0;
    io_y_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      io_x_data = 16'($urandom); io_x_parity = 1'($urandom); io_x_valid = 1'b1;
      if (!a_x_ready) check("stream_ready", 32'd0, 32'd1);
      step();
    end
    io_x_valid = 1'b0;
    step();
    check("stream_delivered", delivered, 32'd100);
    check("stream_count_a", {28'd0, a_count}, 32'd9);
    check("stream_count_b", {16'd0, b_count}, 32'd105);

    // Mid-stream reset with the buffer full, then counter wrap
    io_y_ready = 1'b0;
    send(16'hDEAD, 1'b1);
    send(16'hBEEF, 1'b0);
    check("mid_full", {31'd0, a_x_ready}, 32'd0);
    reset = 1'b0;
    step();
    check("mid_rst_valid", {31'd0, a_y_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, a_x_ready}, 32'd0);
    check("mid_rst_count", {28'd0, a_count}, 32'd0);
    reset = 1'b1;
    io_y_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("mid_no_stale", {31'd0, a_y_valid}, 32'd0);
      step();
    end
    for (int i = 0; i < 17; i++) begin
      io_x_data = 16'(i * 16'h0911); io_x_parity = 1'(i); io_x_valid = 1'b1;
      step();
    end
    io_x_valid = 1'b0;
    step();
    check("wrap_count_a", {28'd0, a_count}, 32'd1);
    check("wrap_count_b", {16'd0, b_count}, 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
